// File: rtl/regfile_param_if.sv
// Bus bundle for regfile_param: read/write ports, clear request and busy flag.
// Parity fault signals exist only when REGFILE_PARITY_EN is defined.
interface regfile_param_if #(
    parameter int XLEN = 32,
    parameter int AW   = 5
);
    logic            clr_req;
    logic [AW-1:0]   a1;
    logic [AW-1:0]   a2;
    logic [AW-1:0]   a3;
    logic [XLEN-1:0] wd3;
    logic            we3;
    logic [XLEN-1:0] rd1;
    logic [XLEN-1:0] rd2;
    logic            busy;
`ifdef REGFILE_PARITY_EN
    logic            inj_perr;
    logic            rd1_perr;
    logic            rd2_perr;

    modport master (
        output clr_req, a1, a2, a3, wd3, we3, inj_perr,
        input  rd1, rd2, busy, rd1_perr, rd2_perr
    );
    modport slave (
        input  clr_req, a1, a2, a3, wd3, we3, inj_perr,
        output rd1, rd2, busy, rd1_perr, rd2_perr
    );
`else
    modport master (
        output clr_req, a1, a2, a3, wd3, we3,
        input  rd1, rd2, busy
    );
    modport slave (
        input  clr_req, a1, a2, a3, wd3, we3,
        output rd1, rd2, busy
    );
`endif
endinterface

// File: rtl/regfile_param.sv
// Parametrised 2R/1W register file with same-cycle write bypass, optional zero
// register and a one-entry-per-cycle clear sweep. Optional parity: REGFILE_PARITY_EN.
module regfile_param #(
    parameter int XLEN     = 32,
    parameter int DEPTH    = 32,
    parameter bit ZERO_REG = 1'b1
) (
    input  logic           clk,
    input  logic           rst,
    regfile_param_if.slave rf
);
    localparam int AW = $clog2(DEPTH);
    localparam logic [AW-1:0] LAST_IDX = AW'(DEPTH - 1);

    localparam logic [0:0] ST_CLEAR = 1'b0;
    localparam logic [0:0] ST_READY = 1'b1;

    logic [0:0]      state_q;
    logic [0:0]      state_d;
    logic [AW-1:0]   clrIdx_q;
    logic [AW-1:0]   clrIdx_d;
    logic [XLEN-1:0] mem_q [DEPTH];

    logic isReady;
    logic writeEn;
    logic zeroA1;
    logic zeroA2;
    logic bypass1;
    logic bypass2;

    assign isReady = (state_q == ST_READY);
    assign zeroA1  = ZERO_REG && (rf.a1 == '0);
    assign zeroA2  = ZERO_REG && (rf.a2 == '0);
    // Writes to the hardwired zero entry are dropped, so they never bypass either.
    assign writeEn = isReady && rf.we3 && !(ZERO_REG && (rf.a3 == '0));
    assign bypass1 = writeEn && (rf.a3 == rf.a1);
    assign bypass2 = writeEn && (rf.a3 == rf.a2);

    always_comb begin
        state_d  = state_q;
        clrIdx_d = clrIdx_q;
        if (state_q == ST_CLEAR) begin
            clrIdx_d = clrIdx_q + 1'b1;
            if (clrIdx_q == LAST_IDX) begin
                state_d = ST_READY;
            end
        end else if (rf.clr_req) begin
            state_d  = ST_CLEAR;
            clrIdx_d = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_CLEAR;
            clrIdx_q <= '0;
        end else begin
            state_q  <= state_d;
            clrIdx_q <= clrIdx_d;
        end
    end

    // The array itself is never reset; the sweep is what zeroes it.
    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                mem_q[clrIdx_q] <= '0;
            end else if (writeEn) begin
                mem_q[rf.a3] <= rf.wd3;
            end
        end
    end

    always_comb begin
        rf.rd1 = '0;
        if (isReady && !zeroA1) begin
            rf.rd1 = bypass1 ? rf.wd3 : mem_q[rf.a1];
        end
    end

    always_comb begin
        rf.rd2 = '0;
        if (isReady && !zeroA2) begin
            rf.rd2 = bypass2 ? rf.wd3 : mem_q[rf.a2];
        end
    end

    assign rf.busy = (state_q == ST_CLEAR);

`ifdef REGFILE_PARITY_EN
    logic parity_q [DEPTH];

    always_ff @(posedge clk) begin
        if (!rst) begin
            if (state_q == ST_CLEAR) begin
                parity_q[clrIdx_q] <= 1'b0;
            end else if (writeEn) begin
                parity_q[rf.a3] <= (^rf.wd3) ^ rf.inj_perr;
            end
        end
    end

    always_comb begin
        rf.rd1_perr = 1'b0;
        rf.rd2_perr = 1'b0;
        if (isReady && !zeroA1 && !bypass1) begin
            rf.rd1_perr = parity_q[rf.a1] != (^mem_q[rf.a1]);
        end
        if (isReady && !zeroA2 && !bypass2) begin
            rf.rd2_perr = parity_q[rf.a2] != (^mem_q[rf.a2]);
        end
    end
`endif
endmodule
